// File: rtl/sram_bus_arbiter.sv
// Two-master arbiter for one asynchronous SRAM bank: picks a requester, sequences
// ce_n/oe_n/we_n for the access and returns read data with a one-cycle ack pulse.
module sram_bus_arbiter #(
    parameter int ADDR_W   = 20,
    parameter int DATA_W   = 32,
    parameter int RD_WAIT  = 1,
    parameter int WR_PULSE = 1,
    parameter int FAIR     = 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  m0_req,
    input  logic                  m0_we,
    input  logic [ADDR_W-1:0]     m0_addr,
    input  logic [DATA_W/8-1:0]   m0_be,
    input  logic [DATA_W-1:0]     m0_wdata,
    output logic [DATA_W-1:0]     m0_rdata,
    output logic                  m0_ack,
    input  logic                  m1_req,
    input  logic                  m1_we,
    input  logic [ADDR_W-1:0]     m1_addr,
    input  logic [DATA_W/8-1:0]   m1_be,
    input  logic [DATA_W-1:0]     m1_wdata,
    output logic [DATA_W-1:0]     m1_rdata,
    output logic                  m1_ack,
    inout  wire  [DATA_W-1:0]     ram_data,
    output logic [ADDR_W-1:0]     ram_addr,
    output logic [DATA_W/8-1:0]   ram_be_n,
    output logic                  ram_ce_n,
    output logic                  ram_oe_n,
    output logic                  ram_we_n,
    output logic                  busy,
    output logic                  grant
);

    // Handshake: a master raises req with stable we/addr/be/wdata and holds them until
    // its ack pulse; the request is latched at grant, so dropping req afterwards is
    // harmless, and req still high after ack counts as a new request.

    typedef enum logic [2:0] {
        S_IDLE, S_RD, S_WR_SETUP, S_WR_PULSE, S_WR_HOLD, S_DONE
    } state_t;

    localparam int         BE_W   = DATA_W / 8;
    localparam logic [2:0] RD_CNT = 3'(RD_WAIT);
    localparam logic [2:0] WR_CNT = 3'(WR_PULSE - 1);

    state_t              state_q, state_d;
    logic [2:0]          cnt_q, cnt_d;
    logic                grant_q, grant_d;
    logic                we_q, we_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [BE_W-1:0]     be_q, be_d;
    logic [DATA_W-1:0]   wdata_q, wdata_d;
    logic [DATA_W-1:0]   m0_rdata_q, m0_rdata_d;
    logic [DATA_W-1:0]   m1_rdata_q, m1_rdata_d;
    logic                m0_ack_q, m0_ack_d;
    logic                m1_ack_q, m1_ack_d;
    logic                ce_n_q, ce_n_d;
    logic                oe_n_q, oe_n_d;
    logic                we_n_q, we_n_d;
    logic [BE_W-1:0]     be_n_q, be_n_d;
    logic                dout_en_q, dout_en_d;
    logic                busy_q, busy_d;
    logic                sel;

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        grant_d    = grant_q;
        we_d       = we_q;
        addr_d     = addr_q;
        be_d       = be_q;
        wdata_d    = wdata_q;
        m0_rdata_d = m0_rdata_q;
        m1_rdata_d = m1_rdata_q;
        sel        = 1'b0;

        case (state_q)
            S_IDLE: begin
                // grant_q doubles as the last-granted index for round-robin
                if (m0_req && m1_req) begin
                    sel = (FAIR != 0) ? ~grant_q : 1'b1;
                end else begin
                    sel = m1_req;
                end
                if (m0_req || m1_req) begin
                    grant_d = sel;
                    we_d    = sel ? m1_we    : m0_we;
                    addr_d  = sel ? m1_addr  : m0_addr;
                    be_d    = sel ? m1_be    : m0_be;
                    wdata_d = sel ? m1_wdata : m0_wdata;
                    cnt_d   = RD_CNT;
                    state_d = (sel ? m1_we : m0_we) ? S_WR_SETUP : S_RD;
                end
            end
            S_RD: begin
                if (cnt_q == 3'd0) begin
                    state_d = S_DONE;
                    if (grant_q) begin
                        m1_rdata_d = ram_data;
                    end else begin
                        m0_rdata_d = ram_data;
                    end
                end else begin
                    cnt_d = cnt_q - 3'd1;
                end
            end
            S_WR_SETUP: begin
                state_d = S_WR_PULSE;
                cnt_d   = WR_CNT;
            end
            S_WR_PULSE: begin
                if (cnt_q == 3'd0) begin
                    state_d = S_WR_HOLD;
                end else begin
                    cnt_d = cnt_q - 3'd1;
                end
            end
            S_WR_HOLD: state_d = S_DONE;
            S_DONE:    state_d = S_IDLE;
            default:   state_d = S_IDLE;
        endcase

        // Strobes are decoded from the next state so the pins come straight from flops
        ce_n_d    = !(state_d inside {S_RD, S_WR_SETUP, S_WR_PULSE, S_WR_HOLD});
        oe_n_d    = (state_d != S_RD);
        we_n_d    = (state_d != S_WR_PULSE);
        dout_en_d = state_d inside {S_WR_SETUP, S_WR_PULSE, S_WR_HOLD};
        be_n_d    = ce_n_d ? {BE_W{1'b1}} : ~be_d;
        m0_ack_d  = (state_d == S_DONE) && !grant_d;
        m1_ack_d  = (state_d == S_DONE) && grant_d;
        busy_d    = (state_d != S_IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            cnt_q      <= 3'd0;
            grant_q    <= 1'b0;
            we_q       <= 1'b0;
            addr_q     <= '0;
            be_q       <= '0;
            wdata_q    <= '0;
            m0_rdata_q <= '0;
            m1_rdata_q <= '0;
            m0_ack_q   <= 1'b0;
            m1_ack_q   <= 1'b0;
            ce_n_q     <= 1'b1;
            oe_n_q     <= 1'b1;
            we_n_q     <= 1'b1;
            be_n_q     <= {BE_W{1'b1}};
            dout_en_q  <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            grant_q    <= grant_d;
            we_q       <= we_d;
            addr_q     <= addr_d;
            be_q       <= be_d;
            wdata_q    <= wdata_d;
            m0_rdata_q <= m0_rdata_d;
            m1_rdata_q <= m1_rdata_d;
            m0_ack_q   <= m0_ack_d;
            m1_ack_q   <= m1_ack_d;
            ce_n_q     <= ce_n_d;
            oe_n_q     <= oe_n_d;
            we_n_q     <= we_n_d;
            be_n_q     <= be_n_d;
            dout_en_q  <= dout_en_d;
            busy_q     <= busy_d;
        end
    end

    assign ram_data = dout_en_q ? wdata_q : {DATA_W{1'bz}};
    assign ram_addr = addr_q;
    assign ram_be_n = be_n_q;
    assign ram_ce_n = ce_n_q;
    assign ram_oe_n = oe_n_q;
    assign ram_we_n = we_n_q;
    assign m0_rdata = m0_rdata_q;
    assign m1_rdata = m1_rdata_q;
    assign m0_ack   = m0_ack_q;
    assign m1_ack   = m1_ack_q;
    assign busy     = busy_q;
    assign grant    = grant_q;

endmodule
